vga_timing_gen: RTL and testbench

//  Produces the 640x480@60Hz VGA raster that drives every sprite/text renderer: pixel coordinates out,

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_gen_if.sv | 31 +++
 rtl/raster_axis_counter.sv | 50 +++++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster constants (default 640x480@60Hz timing) and colour type.
// Renderers import this package for COORD_W and the screen-centre constants.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int SCREEN_CX = VGA_H_ACTIVE / 2;
  localparam int SCREEN_CY = VGA_V_ACTIVE / 2;

  localparam int   VGA_CLK_DIV  = 2;
  localparam logic VGA_SYNC_POL = 1'b0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus: coordinates/strobes out to renderers, colour back in, and the DAC/connector pins.
// master = timing generator, slave = renderer/DAC side.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [COORD_W-1:0] x_pos;
  logic [COORD_W-1:0] y_pos;
  logic               pix_en;
  logic               frame_start;
  logic [23:0]        rgb_in;
  logic               vga_hs;
  logic               vga_vs;
  logic [7:0]         vga_r;
  logic [7:0]         vga_g;
  logic [7:0]         vga_b;
  logic               vga_blank_n;
  logic               vga_clk;

  modport master (
    input  rgb_in,
    output x_pos, y_pos, pix_en, frame_start,
    output vga_hs, vga_vs, vga_r, vga_g, vga_b, vga_blank_n, vga_clk
  );

  modport slave (
    output rgb_in,
    input  x_pos, y_pos, pix_en, frame_start,
    input  vga_hs, vga_vs, vga_r, vga_g, vga_b, vga_blank_n, vga_clk
  );

endinterface

// File: rtl/raster_axis_counter.sv
// One raster axis: wrapping position counter with active-region and sync-pulse decode.
// wrap is the combinational terminal count so the next axis can chain off it.
module raster_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96,
  parameter int ACTIVE     = 640
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  output logic [COORD_W-1:0] count,
  output logic               active,
  output logic               sync_raw,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACT_END    = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_FIRST = COORD_W'(SYNC_START);
  localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(SYNC_START + SYNC_LEN);

  logic [COORD_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign wrap     = (count_q == LAST);
  assign active   = (count_q < ACT_END);
  assign sync_raw = (count_q >= SYNC_FIRST) && (count_q < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz raster generator: pixel divider, x/y counters, and a one-pixel output stage
// that registers renderer colour together with blank and syncs so all describe the same pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter int   CLK_DIV  = VGA_CLK_DIV,
  parameter logic SYNC_POL = VGA_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_timing_gen_if.master   bus
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic SYNC_IDLE = ~SYNC_POL;

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_total_too_large
    $error("vga_timing_gen: raster total exceeds the 10-bit coordinate range");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0]   div_q, div_d;
  logic               pix_en_q, pix_en_d;
  logic               frame_start_q, frame_start_d;
  rgb_t               rgb_q, rgb_d;
  logic               blank_n_q, blank_n_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               vga_clk_q, vga_clk_d;
  logic               pix_active;

  logic [COORD_W-1:0] h_count, v_count;
  logic               h_active, v_active, hs_raw, vs_raw, h_wrap, v_wrap;

  raster_axis_counter #(
    .TOTAL(H_TOT), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC), .ACTIVE(H_ACTIVE)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .en(pix_en_q), .clr(1'b0),
    .count(h_count), .active(h_active), .sync_raw(hs_raw), .wrap(h_wrap)
  );

  raster_axis_counter #(
    .TOTAL(V_TOT), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC), .ACTIVE(V_ACTIVE)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .en(pix_en_q && h_wrap), .clr(1'b0),
    .count(v_count), .active(v_active), .sync_raw(vs_raw), .wrap(v_wrap)
  );

  // The pixel period starts on the clk after pix_en; vga_clk rises once half of it has elapsed.
  always_comb begin
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_en_d      = (div_q == DIV_LAST);
    vga_clk_d     = (CLK_DIV > 1) && (div_q >= DIV_HALF);
    frame_start_d = pix_en_q && h_wrap && v_wrap;
    pix_active    = h_active && v_active;
    rgb_d         = rgb_q;
    blank_n_d     = blank_n_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    if (pix_en_q) begin
      rgb_d     = pix_active ? rgb_t'(bus.rgb_in) : '0;
      blank_n_d = pix_active;
      hs_d      = hs_raw ? SYNC_POL : SYNC_IDLE;
      vs_d      = vs_raw ? SYNC_POL : SYNC_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
      blank_n_q     <= 1'b0;
      hs_q          <= SYNC_IDLE;
      vs_q          <= SYNC_IDLE;
      vga_clk_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
      blank_n_q     <= blank_n_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      vga_clk_q     <= vga_clk_d;
    end
  end

  assign bus.x_pos       = h_count;
  assign bus.y_pos       = v_count;
  assign bus.pix_en      = pix_en_q;
  assign bus.frame_start = frame_start_q;
  assign bus.vga_r       = rgb_q.r;
  assign bus.vga_g       = rgb_q.g;
  assign bus.vga_b       = rgb_q.b;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_clk     = vga_clk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 800-pixel lines, vertical timing shrunk to 12 lines so whole
// frames fit the run; an absolute clock-count model predicts every output on every cycle.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  vga_timing_gen_if bus();

  vga_timing_gen #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(2), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [1:0]  rgb_mode = 2'd0;
  logic [23:0] rand_rgb = 24'h0;

  always_comb begin
    case (rgb_mode)
      2'd1:    bus.rgb_in = 24'hFFFF00;
      2'd2:    bus.rgb_in = {bus.x_pos[7:0], bus.y_pos[7:0], 8'h00};
      default: bus.rgb_in = rand_rgb;
    endcase
  end

  initial forever begin
    @(posedge clk);
    #2;
    rand_rgb = 24'($urandom);
  end

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = clk edges since reset release; pixel advances happen on odd k >= 3.
  int k, a, p, px, py;
  int exp_x, exp_y;
  logic exp_pix_en, exp_fs, exp_hs, exp_vs, exp_blank, exp_vclk;
  logic [23:0] exp_rgb, rgb_hold;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      k = 0; exp_x = 0; exp_y = 0; exp_pix_en = 0; exp_fs = 0;
      exp_hs = 1; exp_vs = 1; exp_rgb = 0; exp_blank = 0; exp_vclk = 0;
    end else begin
      k++;
      a = (k - 1) / 2;
      exp_x = (a % FT) % HT;
      exp_y = (a % FT) / HT;
      exp_pix_en = (k % 2 == 0);
      exp_vclk   = (k % 2 == 0);
      exp_fs = 0;
      if (k % 2 == 1 && k >= 3) begin
        p  = (a - 1) % FT;
        px = p % HT;
        py = p / HT;
        exp_blank = (px < HA) && (py < VA);
        exp_rgb   = exp_blank ? rgb_hold : 24'h0;
        exp_hs    = !((px >= HA + HF) && (px < HA + HF + HS));
        exp_vs    = !((py >= VA + VF) && (py < VA + VF + VS));
        exp_fs    = (a % FT == 0);
      end
    end
  end

  task automatic checkOutput();
    checkVal("x_pos", 32'(bus.x_pos), exp_x);
    checkVal("y_pos", 32'(bus.y_pos), exp_y);
    checkVal("pix_en", 32'(bus.pix_en), 32'(exp_pix_en));
    checkVal("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    checkVal("vga_hs", 32'(bus.vga_hs), 32'(exp_hs));
    checkVal("vga_vs", 32'(bus.vga_vs), 32'(exp_vs));
    checkVal("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(exp_rgb));
    checkVal("blank_n", 32'(bus.vga_blank_n), 32'(exp_blank));
    checkVal("vga_clk", 32'(bus.vga_clk), 32'(exp_vclk));
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_on) checkOutput();
    rgb_hold = bus.rgb_in;
  end

  task automatic applyStimulus(input logic [1:0] mode);
    rgb_mode = mode;
  endtask

  function automatic logic getSig(input int which);
    case (which)
      0:       return bus.vga_hs;
      1:       return bus.vga_vs;
      default: return bus.frame_start;
    endcase
  endfunction

  task automatic waitXY(input int x, input int y, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(bus.x_pos == 10'(x) && bus.y_pos == 10'(y)) && n < budget);
    if (n >= budget) checkVal("wait_xy_timeout", 32'(n), 32'(budget - 1));
  endtask

  task automatic waitSig(input string name, input int which, input logic level, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (getSig(which) !== level && n < budget);
    if (n >= budget) checkVal({name, "_timeout"}, 32'(n), 32'(budget - 1));
  endtask

  task automatic measureLevel(input int which, input logic level, input int budget, output int len);
    len = 0;
    while (getSig(which) === level && len < budget) begin
      @(posedge clk); #1; len++;
    end
  endtask

  int len;

  initial begin
    applyStimulus(2'd0);
    repeat (3) @(posedge clk);
    chk_on = 1'b1;
    #1;
    checkVal("reset_hs", 32'(bus.vga_hs), 32'd1);
    checkVal("reset_blank", 32'(bus.vga_blank_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    @(posedge clk); #1; checkVal("first_pix_en_k1", 32'(bus.pix_en), 32'd0);
    @(posedge clk); #1; checkVal("first_pix_en_k2", 32'(bus.pix_en), 32'd1);
    @(posedge clk); #1; checkVal("x_after_first", 32'(bus.x_pos), 32'd1);

    waitSig("hs_fall", 0, 1'b0, 4 * HT);
    checkVal("x_at_hs_fall", 32'(bus.x_pos), 32'd657);
    measureLevel(0, 1'b0, 4 * HT, len);
    checkVal("hs_width_clks", 32'(len), 32'd192);

    applyStimulus(2'd2);
    waitXY(6, 1, 4 * HT);
    checkVal("coord_pattern_5_1", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h050100);
    checkVal("coord_pattern_blank", 32'(bus.vga_blank_n), 32'd1);

    applyStimulus(2'd1);
    waitXY(101, 2, 4 * HT);
    checkVal("yellow_active", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hFFFF00);
    waitXY(701, 2, 4 * HT);
    checkVal("yellow_hblank", 32'({bus.vga_r, bus.vga_g, bus.vga_b, 7'd0, bus.vga_blank_n}), 32'd0);
    waitXY(1, 7, 4 * FT);
    checkVal("yellow_vblank", 32'({bus.vga_r, bus.vga_g, bus.vga_b, 7'd0, bus.vga_blank_n}), 32'd0);

    applyStimulus(2'd0);
    waitSig("vs_fall", 1, 1'b0, 4 * FT);
    measureLevel(1, 1'b0, 4 * FT, len);
    checkVal("vs_width_clks", 32'(len), 32'(2 * HT * VS));

    waitSig("fs_first", 2, 1'b1, 4 * FT);
    len = 0;
    do begin
      @(posedge clk); #1; len++;
    end while (bus.frame_start !== 1'b1 && len < 4 * FT);
    checkVal("frame_period_clks", 32'(len), 32'(2 * FT));

    waitXY(300, 3, 4 * FT);
    #5;
    rst_n = 1'b0;
    #1;
    checkVal("async_x", 32'(bus.x_pos), 32'd0);
    checkVal("async_y", 32'(bus.y_pos), 32'd0);
    checkVal("async_pins", 32'({bus.vga_r, bus.vga_g, bus.vga_b, 3'd0, bus.vga_hs, bus.vga_vs,
                               bus.vga_blank_n, bus.vga_clk, bus.pix_en}), 32'h18);
    checkOutput();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    len = 0;
    do begin
      @(posedge clk); #1; len++;
    end while (bus.frame_start !== 1'b1 && len < 4 * FT);
    checkVal("restart_to_frame_start", 32'(len), 32'(2 * FT + 1));

    repeat (200) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
